// File: rtl/ehgu_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : ehgu_rst_seq
// Purpose  : Multi-domain reset sequencer. It holds every domain in reset
//            for HOLD_CYCLES edges after rst. It then releases the domains
//            one at a time in ascending index order. After each release it
//            waits for that domain's ack, then waits GAP_CYCLES edges before
//            releasing the next domain. If a domain does not ack within
//            TIMEOUT edges, that domain is put back into reset and a sticky
//            error is raised.
// Ports    : clk         - single clock, all logic on posedge
//            rst         - synchronous active-high reset
//            ack_in      - per-domain ready level
//            restart     - one-cycle request to re-run (DONE/ERROR only)
//            rst_dom_out - registered active-high per-domain resets
//            all_rel     - every domain released and acknowledged
//            busy        - sequence in progress (HOLD, GAP, WAIT_ACK)
//            err         - sticky ack-timeout flag
//            err_dom     - index of the domain that timed out
// Revision : 1.0 - initial release
// ============================================================================
module ehgu_rst_seq #(
    parameter int DOMAINS     = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [DOMAINS-1:0]                            ack_in,
    input  logic                                          restart,
    output logic [DOMAINS-1:0]                            rst_dom_out,
    output logic                                          all_rel,
    output logic                                          busy,
    output logic                                          err,
    output logic [((DOMAINS > 1) ? $clog2(DOMAINS) : 1)-1:0] err_dom
);

    localparam int c_idx_w   = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;
    localparam int c_max_hg  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_max_cnt = (c_max_hg > TIMEOUT) ? c_max_hg : TIMEOUT;
    // The counter only ever holds (limit - 1), so clog2(limit) bits suffice.
    localparam int c_cnt_w   = (c_max_cnt > 1) ? $clog2(c_max_cnt) : 1;

    localparam logic [c_cnt_w-1:0] c_hold_ld = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_ld  = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_to_ld   = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_idx_w-1:0] c_last    = c_idx_w'(DOMAINS - 1);

    localparam logic [2:0] S_HOLD     = 3'd0;
    localparam logic [2:0] S_GAP      = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_ERROR    = 3'd4;

    logic [2:0]         r_state,   w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt,     w_cnt_nxt;
    logic [c_idx_w-1:0] r_idx,     w_idx_nxt;
    logic [DOMAINS-1:0] r_rst_dom, w_rst_dom_nxt;
    logic               r_all_rel, w_all_rel_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_err,     w_err_nxt;
    logic [c_idx_w-1:0] r_err_dom, w_err_dom_nxt;
    logic [c_idx_w-1:0] w_idx_inc;

    assign w_idx_inc = r_idx + c_idx_w'(1);

    // Next-state and next-output logic. Every register update is computed
    // here, so all outputs change on the same edge as the state.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_rst_dom_nxt = r_rst_dom;
        w_all_rel_nxt = r_all_rel;
        w_err_nxt     = r_err;
        w_err_dom_nxt = r_err_dom;

        case (r_state)
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_rst_dom_nxt[0] = 1'b0;
                    w_idx_nxt        = '0;
                    w_cnt_nxt        = c_to_ld;
                    w_state_nxt      = S_WAIT_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            S_WAIT_ACK: begin
                // An ack accepted on the same edge as the final timeout
                // sample wins over the timeout.
                if (ack_in[r_idx]) begin
                    if (r_idx == c_last) begin
                        w_all_rel_nxt = 1'b1;
                        w_state_nxt   = S_DONE;
                    end else begin
                        w_cnt_nxt   = c_gap_ld;
                        w_state_nxt = S_GAP;
                    end
                end else if (r_cnt == '0) begin
                    w_err_nxt            = 1'b1;
                    w_err_dom_nxt        = r_idx;
                    w_rst_dom_nxt[r_idx] = 1'b1;
                    w_state_nxt          = S_ERROR;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_idx_nxt                = w_idx_inc;
                    w_rst_dom_nxt[w_idx_inc] = 1'b0;
                    w_cnt_nxt                = c_to_ld;
                    w_state_nxt              = S_WAIT_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    w_rst_dom_nxt = '1;
                    w_all_rel_nxt = 1'b0;
                    w_err_nxt     = 1'b0;
                    w_err_dom_nxt = '0;
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = c_hold_ld;
                    w_state_nxt   = S_HOLD;
                end
            end
            default: begin
                w_rst_dom_nxt = '1;
                w_all_rel_nxt = 1'b0;
                w_err_nxt     = 1'b0;
                w_err_dom_nxt = '0;
                w_idx_nxt     = '0;
                w_cnt_nxt     = c_hold_ld;
                w_state_nxt   = S_HOLD;
            end
        endcase

        w_busy_nxt = !((w_state_nxt == S_DONE) || (w_state_nxt == S_ERROR));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_HOLD;
            r_cnt     <= c_hold_ld;
            r_idx     <= '0;
            r_rst_dom <= '1;
            r_all_rel <= 1'b0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_err_dom <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_rst_dom <= w_rst_dom_nxt;
            r_all_rel <= w_all_rel_nxt;
            r_busy    <= w_busy_nxt;
            r_err     <= w_err_nxt;
            r_err_dom <= w_err_dom_nxt;
        end
    end

    assign rst_dom_out = r_rst_dom;
    assign all_rel     = r_all_rel;
    assign busy        = r_busy;
    assign err         = r_err;
    assign err_dom     = r_err_dom;

endmodule
`default_nettype wire

// File: tb/tb_ehgu_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ehgu_rst_seq
// Purpose  : Self-checking bench for ehgu_rst_seq (DOMAINS=4, HOLD=8, GAP=4,
//            TIMEOUT=16). It runs directed timing scenarios and then random
//            stimulus. Results are compared each cycle against a schedule
//            model: each domain has a release edge, the edge at which its
//            ack is accepted, and the edge at which it times out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ehgu_rst_seq;

    localparam int DOMAINS = 4;
    localparam int HOLD    = 8;
    localparam int GAP     = 4;
    localparam int TMO     = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         restart;
    logic [3:0]   ack_in;
    logic [3:0]   rst_dom_out;
    logic         all_rel;
    logic         busy;
    logic         err;
    logic [1:0]   err_dom;

    int n_checks = 0;
    int n_errors = 0;

    ehgu_rst_seq #(
        .DOMAINS    (DOMAINS),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ack_in     (ack_in),
        .restart    (restart),
        .rst_dom_out(rst_dom_out),
        .all_rel    (all_rel),
        .busy       (busy),
        .err        (err),
        .err_dom    (err_dom)
    );

    always #5 clk = ~clk;

    // Schedule model. m_n counts edges since the sequence (re)started.
    // m_d is the domain currently being released. m_rel is the edge at
    // which m_d is (or will be) released.
    int m_n, m_d, m_rel, m_err_dom;
    bit m_done, m_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_restart();
        m_n = 0; m_d = 0; m_rel = HOLD; m_done = 0; m_err = 0; m_err_dom = 0;
    endtask

    task automatic model_edge(input logic r, input logic rs, input logic [3:0] a);
        if (r) begin
            model_restart();
        end else if (m_done || m_err) begin
            if (rs) model_restart();
        end else begin
            m_n++;
            if (m_n > m_rel) begin
                if (a[m_d]) begin
                    if (m_d == DOMAINS - 1) m_done = 1;
                    else begin
                        m_d++;
                        m_rel = m_n + GAP;
                    end
                end else if (m_n - m_rel == TMO) begin
                    m_err = 1;
                    m_err_dom = m_d;
                end
            end
        end
    endtask

    function automatic logic [3:0] model_rst_dom();
        logic [3:0] v;
        for (int i = 0; i < DOMAINS; i++) begin
            if (m_err)       v[i] = (i >= m_err_dom);
            else if (m_done) v[i] = 1'b0;
            else             v[i] = !((i < m_d) || (i == m_d && m_n >= m_rel));
        end
        return v;
    endfunction

    // One clock edge. The inputs are applied, the model is advanced, and
    // all outputs are compared #1 after the edge.
    task automatic step(input logic r, input logic rs, input logic [3:0] a);
        rst = r; restart = rs; ack_in = a;
        @(posedge clk);
        model_edge(r, rs, a);
        #1;
        check_val("rst_dom_out", 32'(rst_dom_out), 32'(model_rst_dom()));
        check_val("all_rel", 32'(all_rel), 32'(m_done));
        check_val("busy", 32'(busy), 32'(!(m_done || m_err)));
        check_val("err", 32'(err), 32'(m_err));
        check_val("err_dom", 32'(err_dom), 32'(m_err_dom));
    endtask

    // Runs n edges and records, for each domain, the edge (1-based) on
    // which its reset fell. ack switches from a0 to a1 at edge sw. A
    // restart pulse is issued at edge rs_e (0 means no restart).
    int fall [4];
    task automatic run_track(input int n, input logic [3:0] a0, input int sw,
                             input logic [3:0] a1, input int rs_e);
        logic [3:0] prev;
        for (int i = 0; i < 4; i++) fall[i] = 0;
        for (int e = 1; e <= n; e++) begin
            prev = rst_dom_out;
            step(1'b0, (e == rs_e), (sw != 0 && e >= sw) ? a1 : a0);
            for (int i = 0; i < 4; i++)
                if (prev[i] && !rst_dom_out[i]) fall[i] = e;
        end
    endtask

    initial begin
        logic [3:0] stuck;
        rst = 1'b1; restart = 1'b0; ack_in = 4'h0;
        model_restart();

        // Reset state
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'hF);
        check_val("reset_rst_dom", 32'(rst_dom_out), 32'h0000_000F);
        check_val("reset_busy", 32'(busy), 32'd1);

        // Nominal release timing with every ack high
        run_track(24, 4'hF, 0, 4'hF, 0);
        check_val("nom_fall0", fall[0], 8);
        check_val("nom_fall1", fall[1], 13);
        check_val("nom_fall2", fall[2], 18);
        check_val("nom_fall3", fall[3], 23);
        check_val("nom_all_rel", 32'(all_rel), 32'd1);
        check_val("nom_busy", 32'(busy), 32'd0);

        // Domain 2 never acks, so it times out after edge 34
        step(1'b0, 1'b1, 4'hB);
        run_track(34, 4'hB, 0, 4'hB, 0);
        check_val("tmo_err", 32'(err), 32'd1);
        check_val("tmo_err_dom", 32'(err_dom), 32'd2);
        check_val("tmo_rst_dom", 32'(rst_dom_out), 32'h0000_000C);
        check_val("tmo_all_rel", 32'(all_rel), 32'd0);
        check_val("tmo_busy", 32'(busy), 32'd0);

        // Restart out of ERROR
        step(1'b0, 1'b1, 4'hF);
        check_val("rs_rst_dom", 32'(rst_dom_out), 32'h0000_000F);
        check_val("rs_err", 32'(err), 32'd0);
        run_track(24, 4'hF, 0, 4'hF, 0);
        check_val("rs_fall0", fall[0], 8);
        check_val("rs_fall3", fall[3], 23);
        check_val("rs_all_rel", 32'(all_rel), 32'd1);

        // rst pulse at edge 15 aborts the sequence; domain 0 re-releases
        // 8 edges after rst falls
        step(1'b0, 1'b1, 4'hF);
        run_track(14, 4'hF, 0, 4'hF, 0);
        check_val("abort_pre", 32'(rst_dom_out), 32'h0000_000C);
        step(1'b1, 1'b0, 4'hF);
        check_val("abort_rst_dom", 32'(rst_dom_out), 32'h0000_000F);
        run_track(8, 4'hF, 0, 4'hF, 0);
        check_val("abort_fall0", fall[0], 8);

        // restart during GAP is ignored
        step(1'b1, 1'b0, 4'hF);
        run_track(24, 4'hF, 0, 4'hF, 11);
        check_val("gaprs_fall1", fall[1], 13);
        check_val("gaprs_fall3", fall[3], 23);
        check_val("gaprs_all_rel", 32'(all_rel), 32'd1);

        // Late ack on domain 1 (rises at edge 16)
        step(1'b1, 1'b0, 4'hF);
        run_track(24, 4'hD, 16, 4'hF, 0);
        check_val("late_fall1", fall[1], 13);
        check_val("late_fall2", fall[2], 20);
        check_val("late_err", 32'(err), 32'd0);

        // Random stimulus
        stuck = 4'h0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 63) == 0) stuck = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)) & ~stuck);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
